// File: rtl/timer_pkg.sv
// Shared encodings for the timer controller and the downstream BCD down-counter.
// Holds the 2-bit counter command values and the controller FSM state enum.
package timer_pkg;

  // Command driven to the BCD down-counter; value 3 is never produced.
  typedef enum logic [1:0] {
    CMD_IDLE     = 2'd0,
    CMD_STOP     = 2'd1,
    CMD_COUNTING = 2'd2
  } cmd_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSE  = 2'd2,
    S_FINISH = 2'd3
  } fsm_e;

endpackage

// File: rtl/btn_onepulse.sv
// Raw button -> 2-flop synchronizer -> registered rising-edge pulse (one cycle).
// A button already held when reset releases never produces a pulse until released.
module btn_onepulse (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_prev;
  logic       r_armed;
  logic       r_pulse;
  logic [1:0] r_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
      r_pulse <= 1'b0;
      r_vld   <= 2'b00;
    end else begin
      // NOTE: non-blocking so every stage samples its predecessor's pre-edge value.
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_vld   <= {r_vld[0], 1'b1};
      // Arm only on a genuinely sampled low, not on the zeros left by reset.
      r_armed <= r_armed | (r_vld[1] & ~r_sync2);
      r_pulse <= r_armed & r_sync2 & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/timer_ctrl.sv
// Start/pause/clear controller that paces a BCD down-counter with a divided tick.
// The command output is combinational so COUNTING and the counter's done line align.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       done,
  output logic [1:0] state,
  output logic       running,
  output logic       finished
);

  localparam int                TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);

  fsm_e              r_fsm;
  fsm_e              w_fsm_nxt;
  logic [TICK_W-1:0] r_tick_cnt;
  logic [TICK_W-1:0] w_tick_cnt_nxt;
  logic              w_start_p;
  logic              w_clear_p;
  logic              w_tick;
  cmd_e              w_cmd;

  btn_onepulse u_start (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_start),
    .o_pulse (w_start_p)
  );

  btn_onepulse u_clear (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_clear),
    .o_pulse (w_clear_p)
  );

  assign w_tick = (r_fsm == S_RUN) && (r_tick_cnt == TICK_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm      <= S_IDLE;
      r_tick_cnt <= '0;
    end else begin
      r_fsm      <= w_fsm_nxt;
      r_tick_cnt <= w_tick_cnt_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    w_fsm_nxt      = r_fsm;
    w_tick_cnt_nxt = r_tick_cnt;
    w_cmd          = CMD_STOP;

    case (r_fsm)
      S_IDLE: begin
        w_cmd          = CMD_IDLE;
        w_tick_cnt_nxt = '0;
        if (w_start_p) w_fsm_nxt = S_RUN;
      end
      S_RUN: begin
        w_cmd          = w_tick ? CMD_COUNTING : CMD_STOP;
        w_tick_cnt_nxt = w_tick ? '0 : r_tick_cnt + 1'b1;
        // Completion outranks a simultaneous pause request.
        if (w_tick && done)  w_fsm_nxt = S_FINISH;
        else if (w_start_p)  w_fsm_nxt = S_PAUSE;
      end
      S_PAUSE: begin
        if (w_start_p) w_fsm_nxt = S_RUN;
      end
      S_FINISH: begin
        w_fsm_nxt = S_FINISH;
      end
      default: begin
        w_fsm_nxt = S_IDLE;
      end
    endcase

    if (w_clear_p) begin
      w_fsm_nxt      = S_IDLE;
      w_tick_cnt_nxt = '0;
    end
  end

  assign state    = w_cmd;
  assign running  = (r_fsm == S_RUN);
  assign finished = (r_fsm == S_FINISH);

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl (TICK_DIV=4) with a BCD down-counter model loaded with 05.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_timer_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_start;
  logic       btn_clear;
  logic       done;
  logic [1:0] state;
  logic       running;
  logic       finished;
  logic [7:0] r_bcd;

  int n_cmp = 0;
  int n_bad = 0;

  timer_ctrl #(.TICK_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_start (btn_start),
    .btn_clear (btn_clear),
    .done      (done),
    .state     (state),
    .running   (running),
    .finished  (finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream counter: load on IDLE, decrement on COUNTING, done when COUNTING at 00.
  always @(posedge clk) begin
    if (state == 2'd0)                       r_bcd <= 8'h05;
    else if (state == 2'd2 && r_bcd != 8'h00) r_bcd <= r_bcd - 8'h01;
  end
  assign done = (state == 2'd2) && (r_bcd == 8'h00);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n_c;
    int n_run;
    int n_err;

    rst = 1'b1; btn_start = 1'b0; btn_clear = 1'b0;
    repeat (3) cyc();
    check("rst_state", state, 0);
    check("rst_running", running, 0);
    check("rst_finished", finished, 0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      cyc();
      check("idle_state", state, 0);
      check("idle_running", running, 0);
      check("idle_finished", finished, 0);
    end

    // Start held 10 cycles, run to completion.
    btn_start = 1'b1;
    cyc(); check("lat_n0", running, 0);
    cyc(); check("lat_n1", running, 0);
    cyc(); check("lat_n2", running, 0);
    cyc();
    n_c = 0;
    for (int i = 0; i < 24; i++) begin
      check("run_running", running, 1);
      check("run_state", state, (i % 4 == 3) ? 2 : 1);
      if (state == 2'd2) n_c++;
      if (i == 6) btn_start = 1'b0;
      cyc();
    end
    check("run_counting_total", n_c, 6);
    check("fin_finished", finished, 1);
    check("fin_running", running, 0);
    check("fin_state", state, 1);
    check("fin_bcd", r_bcd, 0);

    btn_start = 1'b1;
    repeat (6) cyc();
    btn_start = 1'b0;
    repeat (4) cyc();
    check("fin_ignore_start", finished, 1);
    check("fin_ignore_state", state, 1);

    btn_clear = 1'b1;
    cyc(); cyc(); cyc();
    check("clr_lat", finished, 1);
    cyc();
    check("clr_state", state, 0);
    check("clr_finished", finished, 0);
    btn_clear = 1'b0;
    repeat (4) cyc();
    check("clr_bcd_reload", r_bcd, 5);

    // Pause while the tick counter is at 2, then resume.
    btn_start = 1'b1; cyc();
    btn_start = 1'b0; cyc(); cyc();
    btn_start = 1'b1; cyc();
    check("p_idx0", state, 1);
    cyc(); check("p_idx1", state, 1);
    cyc(); check("p_idx2", running, 1);
    cyc();
    check("p_paused", running, 0);
    check("p_paused_state", state, 1);
    btn_start = 1'b0;
    n_err = 0;
    repeat (50) begin
      cyc();
      if (running || state != 2'd1) n_err++;
    end
    check("p_hold", n_err, 0);
    btn_start = 1'b1; cyc();
    btn_start = 1'b0; cyc(); cyc();
    check("p_pre_resume", running, 0);
    cyc();
    check("p_resume_running", running, 1);
    check("p_resume_counting", state, 2);
    n_run = 4;
    n_c = 1;
    for (int k = 0; k < 100 && !finished; k++) begin
      cyc();
      if (running) n_run++;
      if (state == 2'd2) n_c++;
    end
    check("p_run_cycles", n_run, 24);
    check("p_counting_total", n_c, 6);
    check("p_finished", finished, 1);
    btn_clear = 1'b1; cyc();
    btn_clear = 1'b0; repeat (5) cyc();
    check("p_clr_state", state, 0);

    // Clear and start rising together during RUN.
    btn_start = 1'b1; repeat (4) cyc();
    check("cs_running", running, 1);
    btn_start = 1'b0; cyc();
    btn_clear = 1'b1; btn_start = 1'b1;
    cyc(); cyc(); cyc();
    check("cs_pulse_cycle", running, 1);
    cyc();
    check("cs_state", state, 0);
    check("cs_running_off", running, 0);
    check("cs_finished", finished, 0);
    btn_clear = 1'b0; btn_start = 1'b0;
    repeat (4) cyc();
    btn_start = 1'b1; repeat (4) cyc();
    for (int i = 0; i < 4; i++) begin
      check("cs_restart_state", state, (i == 3) ? 2 : 1);
      cyc();
    end
    btn_start = 1'b0;
    btn_clear = 1'b1; repeat (4) cyc();
    check("cs_clr2", state, 0);
    btn_clear = 1'b0; repeat (4) cyc();

    // Reset mid-run with start held across release.
    btn_start = 1'b1; repeat (4) cyc();
    check("r_running", running, 1);
    cyc();
    rst = 1'b1; cyc();
    check("r_state", state, 0);
    check("r_running_off", running, 0);
    cyc();
    rst = 1'b0;
    n_err = 0;
    repeat (10) begin
      cyc();
      if (running || state != 2'd0) n_err++;
    end
    check("r_no_spurious", n_err, 0);
    btn_start = 1'b0; repeat (5) cyc();
    check("r_idle_state", state, 0);
    btn_start = 1'b1; repeat (4) cyc();
    check("r_rearm", running, 1);
    btn_start = 1'b0;
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 100_000_000: clk cycles per count step (1 s at 100 MHz); legal range 2..2^27.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 btn_start  input  1  raw start/pause button, asynchronous, active-high.
REQ-005 btn_clear  input  1  raw clear button, asynchronous, active-high.
REQ-006 done  input  1  from downstream BCD down-counter; high in a cycle where counter sees COUNTING and holds 00.
REQ-007 state  output  2  command to BCD down-counter: IDLE=0 (load initial), STOP=1 (hold), COUNTING=2 (decrement this cycle); 3 never driven.
REQ-008 running  output  1  high while FSM in RUN.
REQ-009 finished  output  1  high while FSM in FINISH.

Function
REQ-010 Each button SHALL pass a 2-flop synchronizer plus a rising-edge detector producing a one-cycle pulse (start_p, clear_p); a level held high yields exactly one pulse.
REQ-011 Button asserted before rising edge n SHALL produce its pulse in the cycle after edge n+2; the FSM reacts at edge n+3.
REQ-012 Internal FSM states: S_IDLE, S_RUN, S_PAUSE, S_FINISH.
REQ-013 S_IDLE: state=IDLE; tick counter held at 0; start_p -> S_RUN.
REQ-014 S_RUN: tick counter increments each cycle, wraps TICK_DIV-1 -> 0; tick=1 in the cycle counter equals TICK_DIV-1; state=COUNTING when tick=1, else STOP.
REQ-015 S_RUN: start_p -> S_PAUSE; tick && done -> S_FINISH; start_p and tick in same cycle: tick's COUNTING is still issued, then S_PAUSE (or S_FINISH if done, FINISH wins).
REQ-016 S_PAUSE: state=STOP; tick counter holds its value; start_p -> S_RUN, resuming from held value (no step lost or repeated).
REQ-017 S_FINISH: state=STOP; finished=1; start_p ignored.
REQ-018 clear_p in any state -> S_IDLE at next edge with tick counter cleared; clear_p overrides start_p, tick and done.
REQ-019 state SHALL be combinational from FSM state and tick (no extra register), so COUNTING and done align in the same cycle.
REQ-020 Outside S_RUN, state SHALL never equal COUNTING; done outside a tick cycle is ignored.
REQ-021 Tick counter width SHALL be ceil(log2(TICK_DIV)) bits; no overflow beyond TICK_DIV-1.

Reset
REQ-022 rst high at a rising edge: FSM -> S_IDLE, tick counter 0, synchronizer and edge flops 0.
REQ-023 Output values during/after reset: state=IDLE(0), running=0, finished=0.
REQ-024 Reset asserted mid-RUN or mid-PAUSE SHALL abandon the run; no pulse generated from a button held across reset release.

Structure
REQ-025 Shared package timer_pkg SHALL hold the 2-bit counter command encodings (IDLE, STOP, COUNTING) and the FSM state enum, used by timer_ctrl and BCD down-counter alike.
REQ-026 One sub-module btn_onepulse (synchronizer + edge detect), instantiated twice.

Verification (TICK_DIV=4, downstream counter 05 initial)
REQ-027 Reset then idle: state=0, running=0, finished=0 for 20 cycles with buttons low.
REQ-028 btn_start held 10 cycles -> exactly one start_p; running=1 from edge n+3; state=2 every 4th cycle, 1 otherwise.
REQ-029 Run to completion with counter model: 5 COUNTING cycles decrement 05->00, 6th COUNTING with done=1 -> finished=1, state=1 thereafter; further start ignored.
REQ-030 Pause at tick counter 2, wait 50 cycles, resume -> next COUNTING exactly 1 cycle after resume; total COUNTING count matches no-pause run.
REQ-031 btn_clear and btn_start rising same cycle during RUN -> S_IDLE, state=0, tick counter 0.
REQ-032 rst asserted during RUN with btn_start held high through release -> S_IDLE, no spurious start after release.
